// File: rtl/beat_tempo_gen.sv
// Tempo generator: programmable-period subdivision tick with beat/bar strobes,
// musical position counters, pause/stop control and tick-aligned period updates.
module beat_tempo_gen #(
    parameter int PERIOD_W       = 25,
    parameter int DEFAULT_PERIOD = 15000000,
    parameter int SUBDIV         = 2,
    parameter int BEATS_PER_BAR  = 4,
    parameter int BAR_W          = 8,
    localparam int SUB_W  = (SUBDIV > 1) ? $clog2(SUBDIV) : 1,
    localparam int BEAT_W = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pause,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_we,
    output logic                tick,
    output logic                beat,
    output logic                bar,
    output logic [SUB_W-1:0]    sub_idx,
    output logic [BEAT_W-1:0]   beat_idx,
    output logic [BAR_W-1:0]    bar_count,
    output logic [PERIOD_W-1:0] period_cur
);

    localparam logic [PERIOD_W-1:0] PERIOD_MIN  = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] PERIOD_RST  = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [SUB_W-1:0]    SUB_LAST    = SUB_W'(SUBDIV - 1);
    localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'(BEATS_PER_BAR - 1);

    logic [PERIOD_W-1:0] t_q, t_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [BEAT_W-1:0]   beat_idx_q, beat_idx_d;
    logic [BAR_W-1:0]    bar_cnt_q, bar_cnt_d;
    logic                tick_q, tick_d;
    logic                beat_q, beat_d;
    logic                bar_q, bar_d;

    logic                run;
    logic                at_end;
    logic [PERIOD_W-1:0] wr_val;

    assign run    = !stop && !pause;
    assign at_end = (t_q == period_q - PERIOD_W'(1));
    assign wr_val = (period_in < PERIOD_MIN) ? PERIOD_MIN : period_in;

    // Position and strobe update; indices move only on a tick edge.
    always_comb begin
        t_d        = t_q;
        sub_d      = sub_q;
        beat_idx_d = beat_idx_q;
        bar_cnt_d  = bar_cnt_q;
        tick_d     = 1'b0;
        beat_d     = 1'b0;
        bar_d      = 1'b0;
        if (stop) begin
            t_d        = '0;
            sub_d      = '0;
            beat_idx_d = '0;
            bar_cnt_d  = '0;
        end else if (run) begin
            if (at_end) begin
                t_d    = '0;
                tick_d = 1'b1;
                if (sub_q == SUB_LAST) begin
                    sub_d  = '0;
                    beat_d = 1'b1;
                    if (beat_idx_q == BEAT_LAST) begin
                        beat_idx_d = '0;
                        bar_d      = 1'b1;
                        bar_cnt_d  = bar_cnt_q + BAR_W'(1);
                    end else begin
                        beat_idx_d = beat_idx_q + BEAT_W'(1);
                    end
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end else begin
                t_d = t_q + PERIOD_W'(1);
            end
        end
    end

    // Period handling: writes park in pending and swap in only at a tick edge,
    // so an interval already under way keeps its length. Stopped: apply at once.
    always_comb begin
        period_d   = period_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (stop) begin
            if (period_we) begin
                period_d   = wr_val;
                pend_vld_d = 1'b0;
            end
        end else begin
            if (period_we) begin
                pend_d     = wr_val;
                pend_vld_d = 1'b1;
            end
            if (run && at_end) begin
                if (period_we) begin
                    period_d   = wr_val;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    period_d   = pend_q;
                    pend_vld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t_q        <= '0;
            period_q   <= PERIOD_RST;
            pend_q     <= PERIOD_RST;
            pend_vld_q <= 1'b0;
            sub_q      <= '0;
            beat_idx_q <= '0;
            bar_cnt_q  <= '0;
            tick_q     <= 1'b0;
            beat_q     <= 1'b0;
            bar_q      <= 1'b0;
        end else begin
            t_q        <= t_d;
            period_q   <= period_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sub_q      <= sub_d;
            beat_idx_q <= beat_idx_d;
            bar_cnt_q  <= bar_cnt_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            bar_q      <= bar_d;
        end
    end

    assign tick       = tick_q;
    assign beat       = beat_q;
    assign bar        = bar_q;
    assign sub_idx    = sub_q;
    assign beat_idx   = beat_idx_q;
    assign bar_count  = bar_cnt_q;
    assign period_cur = period_q;

endmodule

// File: tb/tb_beat_tempo_gen.sv
// Directed bench for beat_tempo_gen (P=5, SUBDIV=2, BEATS_PER_BAR=3): free run,
// bar wrap, period writes, pause, stop+pause and async reset with a frozen clock.
module tb_beat_tempo_gen;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       resetn;
    logic       pause, stop, period_we;
    logic [7:0] period_in;
    logic       tick, beat, bar;
    logic [0:0] sub_idx;
    logic [1:0] beat_idx;
    logic [7:0] bar_count, period_cur;

    int n_cmp = 0;
    int n_err = 0;
    int nticks = 0;     // ticks since last position clear
    int exp_per = 5;

    beat_tempo_gen #(
        .PERIOD_W(8), .DEFAULT_PERIOD(5), .SUBDIV(2), .BEATS_PER_BAR(3), .BAR_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .pause(pause), .stop(stop),
        .period_in(period_in), .period_we(period_we),
        .tick(tick), .beat(beat), .bar(bar), .sub_idx(sub_idx),
        .beat_idx(beat_idx), .bar_count(bar_count), .period_cur(period_cur)
    );

    always #5 clk = clk_en ? ~clk : clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d exp %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge and check strobes/indices against the tick-count model.
    task automatic step_chk(input bit et);
        bit eb, ebar;
        step();
        eb   = 1'b0;
        ebar = 1'b0;
        if (et) begin
            nticks++;
            eb   = (nticks % 2 == 0);
            ebar = (nticks % 6 == 0);
        end
        chk("tick", 32'(tick), 32'(et));
        chk("beat", 32'(beat), 32'(eb));
        chk("bar", 32'(bar), 32'(ebar));
        chk("sub_idx", 32'(sub_idx), 32'(nticks % 2));
        chk("beat_idx", 32'(beat_idx), 32'((nticks / 2) % 3));
        chk("bar_count", 32'(bar_count), 32'((nticks / 6) % 256));
        chk("period_cur", 32'(period_cur), 32'(exp_per));
    endtask

    task automatic chk_reset_vals();
        chk("rst_tick", 32'(tick), 32'(0));
        chk("rst_beat", 32'(beat), 32'(0));
        chk("rst_bar", 32'(bar), 32'(0));
        chk("rst_sub", 32'(sub_idx), 32'(0));
        chk("rst_beat_idx", 32'(beat_idx), 32'(0));
        chk("rst_bar_count", 32'(bar_count), 32'(0));
        chk("rst_period", 32'(period_cur), 32'(5));
    endtask

    initial begin
        resetn    = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        period_we = 1'b0;
        period_in = 8'd0;
        repeat (3) step();
        chk_reset_vals();
        resetn = 1'b1;

        // Free run: ticks every 5, beats every 10, bars every 30; 256 bars wraps bar_count.
        for (int e = 1; e <= 7680; e++) step_chk(e % 5 == 0);
        chk("bar_wrap_count", 32'(bar_count), 32'(0));
        chk("bar_wrap_strobe", 32'(bar), 32'(1));

        // k counts edges after the tick at 7680 (t = 0 there).
        for (int k = 1; k <= 61; k++) begin
            period_we = (k == 3 || k == 12 || k == 13 || k == 17 || k == 24 || k == 37);
            case (k)
                3:       period_in = 8'd3;
                12:      period_in = 8'd3;
                13:      period_in = 8'd0;
                17:      period_in = 8'd5;
                24:      period_in = 8'd4;
                37:      period_in = 8'd9;
                default: period_in = 8'hAA;
            endcase
            stop  = (k >= 35 && k <= 40);
            pause = (k >= 22 && k <= 28) || (k >= 35 && k <= 40);
            if (k == 35) nticks = 0;
            if      (k < 5)  exp_per = 5;
            else if (k < 14) exp_per = 3;
            else if (k < 18) exp_per = 2;
            else if (k < 30) exp_per = 5;
            else if (k < 37) exp_per = 4;
            else             exp_per = 9;
            step_chk(k == 5 || k == 8 || k == 11 || k == 14 || k == 16 || k == 18 ||
                     k == 30 || k == 34 || k == 49 || k == 58);
            if (k == 49) chk("stop_release_sub", 32'(sub_idx), 32'(1));
        end
        period_we = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;

        // Async reset mid-interval with the clock frozen.
        clk_en = 1'b0;
        #20;
        resetn = 1'b0;
        #2;
        chk_reset_vals();
        #5;
        resetn = 1'b1;
        #5;
        clk_en  = 1'b1;
        nticks  = 0;
        exp_per = 5;
        for (int e = 1; e <= 10; e++) step_chk(e % 5 == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/beat_tempo_gen.md
# beat_tempo_gen

Parametrised tempo generator that replaces the fixed eighth-note rate driver in the note-drop display. It produces a single-cycle subdivision tick, beat and bar strobes with runtime-programmable period, plus pause/stop control and musical position counters. These feed the game FSM, note register shifting and the scoring comparator.

## Interface
- PERIOD_W, 25: width of the period counter and `period_in`.
- DEFAULT_PERIOD, 15000000: tick period in clk cycles after reset; must be ≥ 2 and < 2^PERIOD_W.
- SUBDIV, 2: ticks per beat; ≥ 1.
- BEATS_PER_BAR, 4: beats per bar; ≥ 1.
- BAR_W, 8: width of `bar_count`.
- clk  in  1  system clock (50 MHz on board).
- resetn  in  1  asynchronous, active-low reset.
- pause  in  1  level; freezes all counters, suppresses strobes.
- stop  in  1  level, synchronous; clears position and holds idle; priority over pause.
- period_in  in  PERIOD_W  requested tick period in clk cycles.
- period_we  in  1  one-cycle write strobe for `period_in`.
- tick  out  1  one-cycle strobe per subdivision.
- beat  out  1  one-cycle strobe on the tick that starts a beat.
- bar  out  1  one-cycle strobe on the tick that starts a bar.
- sub_idx  out  max(1,clog2(SUBDIV))  subdivision within beat.
- beat_idx  out  max(1,clog2(BEATS_PER_BAR))  beat within bar.
- bar_count  out  BAR_W  completed bars, wraps modulo 2^BAR_W.
- period_cur  out  PERIOD_W  period currently in force.

## Operation
- Interval counter `t` runs 0..period_cur−1. On the edge where t == period_cur−1 and not paused/stopped: t←0, tick←1, sub_idx advances.
- sub_idx wraps SUBDIV−1→0; on that wrap beat←1 and beat_idx advances. beat_idx wraps BEATS_PER_BAR−1→0; on that wrap bar←1 and bar_count increments (wraps).
- Strobes coincide in one cycle with already-updated indices. Every bar is a beat. Every beat is a tick.
- Period write: `period_we` latches `period_in` into a pending register and sets pending-valid. Values < 2 clamp to 2. A later write before application overwrites the pending value.
- Application: the pending value becomes period_cur on the next tick edge, so the new interval uses it. The in-flight interval is never shortened or stretched.
- While stop = 1, a write applies immediately on the write edge.
- A write coincident with a tick edge applies at that edge.
- Pause: t, indices and period_cur hold and strobes stay 0. Writes are still latched (pending). On release, counting resumes from the held t.
- Stop: each edge forces t, sub_idx, beat_idx, bar_count and strobes to 0. On release, the first tick fires after period_cur edges with sub_idx = 1 (or 0 if SUBDIV = 1).
- stop and pause together: stop behaviour.

## Timing
- Reset (async, immediate): t = 0, tick = beat = bar = 0, sub_idx = beat_idx = 0, bar_count = 0, period_cur = DEFAULT_PERIOD, pending-valid = 0.
- After reset/stop release, the first tick is high in the cycle after the P-th rising edge. Subsequent ticks are every P cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- period_cur updates in the same cycle the tick carrying it goes high.
- Strobe width is exactly 1 cycle. Ticks are never back-to-back, since P ≥ 2.
- Pause asserted on the edge where t == P−1: no tick that edge; the tick fires on the first unpaused edge.

## Test plan
Use PERIOD_W = 8, DEFAULT_PERIOD = 5, SUBDIV = 2, BEATS_PER_BAR = 3.
- Free run from reset release:
  - tick on edges 5, 10, 15, ….
  - beat on 10, 20, 30 (sub_idx = 0 there).
  - bar on 30 with beat_idx = 0 and bar_count = 1.
  - bar_count wraps 255→0 after 256 bars.
- Period change: period_we with 3 when t = 2:
  - current interval ends on edge 5 as scheduled, period_cur = 3 there.
  - next ticks on 8, 11.
  - second write of 0 before application: period_cur becomes 2, not 3.
- Pause for 7 cycles starting at t = 3:
  - the tick is delayed by exactly 7 cycles, indices are unchanged.
  - a write during pause applies at the delayed tick.
- stop with pause both high mid-bar:
  - all counters 0 next edge, no strobes while held.
  - a write of 9 applies immediately.
  - on release, first tick after 9 edges.
- Async reset mid-interval with clk stopped:
  - all outputs reach reset values without a clock edge, period_cur = 5.
  - after release, tick on the 5th edge.
